// File: rtl/sha_pad_stream.sv
// Streaming SHA-256 message padder: passes message words through, then appends the
// 0x80 marker, zero fill and 64-bit bit length, and reports the block count per message.
module sha_pad_stream #(
    parameter int WORD_W    = 32,
    parameter int MSG_LEN_W = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WORD_W-1:0]             in_data,
    input  logic                          in_last,
    input  logic [$clog2(WORD_W/8):0]     in_bytes,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WORD_W-1:0]             out_data,
    output logic                          out_block_last,
    output logic                          out_msg_last,
    output logic [MSG_LEN_W-9:0]          block_count,
    output logic                          overflow
);

    localparam int WPB   = 512 / WORD_W;
    localparam int LW    = 64 / WORD_W;
    localparam int BPW   = WORD_W / 8;
    localparam int IDX_W = $clog2(WPB);
    localparam int IB_W  = $clog2(BPW) + 1;
    localparam int BC_W  = MSG_LEN_W - 3;
    localparam int BLK_W = MSG_LEN_W - 8;

    localparam logic [1:0] ST_DATA = 2'd0;
    localparam logic [1:0] ST_PAD  = 2'd1;
    localparam logic [1:0] ST_ZERO = 2'd2;
    localparam logic [1:0] ST_LEN  = 2'd3;

    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(WPB - 1);
    localparam logic [IDX_W-1:0]  IDX_LEN    = IDX_W'(WPB - LW);
    localparam logic [IB_W-1:0]   BYTES_FULL = IB_W'(BPW);
    localparam logic [WORD_W-1:0] PAD_WORD   = WORD_W'(8'h80) << (WORD_W - 8);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] widx_q, widx_d;
    logic [BC_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic [BLK_W-1:0] block_count_q, block_count_d;
    logic             overflow_q, overflow_d;

    logic [WORD_W-1:0] last_word;
    logic [63:0]       len_bits;
    logic [IDX_W-1:0]  widx_inc;
    logic [IDX_W-1:0]  lidx;
    logic [1:0]        after_marker;
    logic [IB_W-1:0]   add_bytes;
    logic [BC_W:0]     byte_sum;
    logic              hs;

    // Final message word: keep the valid bytes, place the marker right after them.
    always_comb begin
        last_word = '0;
        for (int b = 0; b < BPW; b++) begin
            if (b < int'(in_bytes)) begin
                last_word[WORD_W-1-8*b -: 8] = in_data[WORD_W-1-8*b -: 8];
            end else if (b == int'(in_bytes)) begin
                last_word[WORD_W-1-8*b -: 8] = 8'h80;
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default here so no path through the case can infer a latch.
        state_d        = state_q;
        widx_d         = widx_q;
        byte_cnt_d     = byte_cnt_q;
        blk_cnt_d      = blk_cnt_q;
        block_count_d  = block_count_q;
        overflow_d     = overflow_q;
        out_valid      = 1'b1;
        in_ready       = 1'b0;
        out_data       = '0;
        out_msg_last   = 1'b0;
        len_bits       = '0;
        len_bits[MSG_LEN_W-1:0] = {byte_cnt_q, 3'b000};
        widx_inc       = (widx_q == IDX_LAST) ? '0 : widx_q + 1'b1;
        lidx           = widx_q - IDX_LEN;
        after_marker   = (widx_inc == IDX_LEN) ? ST_LEN : ST_ZERO;
        add_bytes      = in_last ? in_bytes : BYTES_FULL;
        byte_sum       = {1'b0, byte_cnt_q} + (BC_W+1)'(add_bytes);

        case (state_q)
            ST_DATA: begin
                out_valid = in_valid;
                in_ready  = out_ready;
                out_data  = (in_last && in_bytes < BYTES_FULL) ? last_word : in_data;
            end
            ST_PAD: out_data = PAD_WORD;
            ST_ZERO: out_data = '0;
            default: begin
                for (int k = 0; k < LW; k++) begin
                    if (lidx == IDX_W'(k)) out_data = len_bits[WORD_W*(LW-1-k) +: WORD_W];
                end
                out_msg_last = (widx_q == IDX_LAST);
            end
        endcase

        out_block_last = out_valid && (widx_q == IDX_LAST);
        hs             = out_valid && out_ready;

        if (hs) begin
            widx_d = widx_inc;
            if (out_block_last) blk_cnt_d = blk_cnt_q + 1'b1;
            case (state_q)
                ST_DATA: begin
                    // An empty byte counter means this is the first word of a new message.
                    if (byte_cnt_q == '0) overflow_d = 1'b0;
                    if (byte_sum[BC_W]) begin
                        byte_cnt_d = '1;
                        overflow_d = 1'b1;
                    end else begin
                        byte_cnt_d = byte_sum[BC_W-1:0];
                    end
                    if (in_last) state_d = (in_bytes == BYTES_FULL) ? ST_PAD : after_marker;
                end
                ST_PAD:  state_d = after_marker;
                ST_ZERO: if (widx_inc == IDX_LEN) state_d = ST_LEN;
                default: begin
                    if (out_msg_last) begin
                        block_count_d = blk_cnt_q + 1'b1;
                        state_d       = ST_DATA;
                        widx_d        = '0;
                        byte_cnt_d    = '0;
                        blk_cnt_d     = '0;
                    end
                end
            endcase
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_DATA;
            widx_q        <= '0;
            byte_cnt_q    <= '0;
            blk_cnt_q     <= '0;
            block_count_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            widx_q        <= widx_d;
            byte_cnt_q    <= byte_cnt_d;
            blk_cnt_q     <= blk_cnt_d;
            block_count_q <= block_count_d;
            overflow_q    <= overflow_d;
        end
    end

    assign block_count = block_count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_sha_pad_stream.sv
// Bench for sha_pad_stream: a 32-bit default build and a 64-bit/16-bit-length build,
// checked against a byte-level padding model through per-instance scoreboards.
module tb_sha_pad_stream;

    typedef struct packed {
        logic [63:0] data;
        logic        bl;
        logic        ml;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic out_ready;
    logic bp_en;
    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_obl, a_oml, a_overflow;
    logic [31:0] a_in_data, a_out_data;
    logic [2:0]  a_in_bytes;
    logic [23:0] a_block_count;

    logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_obl, b_oml, b_overflow;
    logic [63:0] b_in_data, b_out_data;
    logic [3:0]  b_in_bytes;
    logic [7:0]  b_block_count;

    int checks = 0;
    int errors = 0;
    exp_t exp_a[$];
    exp_t exp_b[$];
    logic [7:0] msg_q[$];

    sha_pad_stream #(.WORD_W(32), .MSG_LEN_W(32)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_last(a_in_last), .in_bytes(a_in_bytes),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_block_last(a_obl), .out_msg_last(a_oml),
        .block_count(a_block_count), .overflow(a_overflow)
    );

    sha_pad_stream #(.WORD_W(64), .MSG_LEN_W(16)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_last(b_in_last), .in_bytes(b_in_bytes),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_block_last(b_obl), .out_msg_last(b_oml),
        .block_count(b_block_count), .overflow(b_overflow)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic fill_msg(input int n, input int seed);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back(8'((i * 7 + seed) & 255));
    endtask

    // Byte-level reference: message, 0x80, zeros to 56 mod 64, 8-byte big-endian length.
    task automatic build_expected(input bit sel);
        logic [7:0]  pq[$];
        logic [63:0] nbytes, lenbits, d;
        int bpw, wpb, nw;
        exp_t e;
        pq = msg_q;
        nbytes = 64'(msg_q.size());
        pq.push_back(8'h80);
        while (pq.size() % 64 != 56) pq.push_back(8'h00);
        if (sel && nbytes > 64'd8191) nbytes = 64'd8191;
        lenbits = nbytes * 8;
        for (int i = 7; i >= 0; i--) pq.push_back(lenbits[8*i +: 8]);
        bpw = sel ? 8 : 4;
        wpb = 64 / bpw;
        nw  = pq.size() / bpw;
        for (int j = 0; j < nw; j++) begin
            d = '0;
            for (int k = 0; k < bpw; k++) d = (d << 8) | 64'(pq[j*bpw+k]);
            e.data = d;
            e.bl   = (j % wpb == wpb - 1);
            e.ml   = (j == nw - 1);
            if (sel) exp_b.push_back(e);
            else     exp_a.push_back(e);
        end
    endtask

    task automatic drive_words(input bit sel);
        int n, bpw, nw, nv, t;
        logic [63:0] w;
        logic acc;
        n   = msg_q.size();
        bpw = sel ? 8 : 4;
        nw  = (n == 0) ? 1 : (n + bpw - 1) / bpw;
        for (int j = 0; j < nw; j++) begin
            w = '0;
            for (int k = 0; k < bpw; k++) begin
                w = w << 8;
                w[7:0] = (j*bpw + k < n) ? msg_q[j*bpw+k] : 8'hC3;
            end
            nv = (j == nw - 1) ? n - j*bpw : bpw;
            if (sel) begin
                b_in_valid = 1'b1; b_in_data = w; b_in_last = (j == nw - 1); b_in_bytes = 4'(nv);
            end else begin
                a_in_valid = 1'b1; a_in_data = w[31:0]; a_in_last = (j == nw - 1); a_in_bytes = 3'(nv);
            end
            t = 0;
            do begin
                @(negedge clk);
                acc = sel ? b_in_ready : a_in_ready;
                @(posedge clk);
                #1;
                t++;
            end while (!acc && t < 500);
            if (!acc) chk("accept_timeout", {63'd0, acc}, 64'd1);
        end
        a_in_valid = 1'b0; a_in_last = 1'b0;
        b_in_valid = 1'b0; b_in_last = 1'b0;
    endtask

    task automatic send_msg(input bit sel, input string tag);
        int n, t, pending;
        logic [63:0] exp_blocks;
        n = msg_q.size();
        exp_blocks = 64'((n * 8 + 64) / 512 + 1);
        build_expected(sel);
        drive_words(sel);
        t = 0;
        pending = sel ? exp_b.size() : exp_a.size();
        while (pending != 0 && t < 5000) begin
            @(negedge clk);
            t++;
            pending = sel ? exp_b.size() : exp_a.size();
        end
        chk({tag, "_drain"}, 64'(pending), 64'd0);
        @(posedge clk);
        #1;
        if (sel) begin
            chk({tag, "_block_count"}, 64'(b_block_count), exp_blocks);
            chk({tag, "_overflow"}, {63'd0, b_overflow}, {63'd0, n > 8191});
        end else begin
            chk({tag, "_block_count"}, 64'(a_block_count), exp_blocks);
            chk({tag, "_overflow"}, {63'd0, a_overflow}, 64'd0);
        end
    endtask

    // Output monitor: pops the scoreboard on each handshake and checks hold during stalls.
    initial begin
        exp_t e;
        logic a_hold_v, b_hold_v;
        logic [31:0] a_hold;
        logic [63:0] b_hold;
        a_hold_v = 1'b0; b_hold_v = 1'b0; a_hold = '0; b_hold = '0;
        forever begin
            @(negedge clk);
            if (a_hold_v && a_out_valid) chk("a_stall_hold", 64'(a_out_data), 64'(a_hold));
            a_hold_v = a_out_valid && !out_ready;
            a_hold   = a_out_data;
            if (a_out_valid && out_ready) begin
                chk("a_unexpected_word", 64'(exp_a.size() != 0), 64'd1);
                if (exp_a.size() != 0) begin
                    e = exp_a.pop_front();
                    chk("a_word", {30'd0, a_out_data, a_obl, a_oml}, {30'd0, e.data[31:0], e.bl, e.ml});
                end
            end
            if (b_hold_v && b_out_valid) chk("b_stall_hold", b_out_data, b_hold);
            b_hold_v = b_out_valid && !out_ready;
            b_hold   = b_out_data;
            if (b_out_valid && out_ready) begin
                chk("b_unexpected_word", 64'(exp_b.size() != 0), 64'd1);
                if (exp_b.size() != 0) begin
                    e = exp_b.pop_front();
                    chk("b_word", b_out_data, e.data);
                    chk("b_flags", {62'd0, b_obl, b_oml}, {62'd0, e.bl, e.ml});
                end
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        bp_en = 1'b0;
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_in_last = 1'b0; a_in_bytes = '0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_in_bytes = '0;
        #2;
        chk("rst_a_out_valid", {63'd0, a_out_valid}, 64'd0);
        chk("rst_a_in_ready", {63'd0, a_in_ready}, {63'd0, out_ready});
        chk("rst_a_flags", {62'd0, a_obl, a_oml}, 64'd0);
        chk("rst_a_block_count", 64'(a_block_count), 64'd0);
        chk("rst_a_overflow", {63'd0, a_overflow}, 64'd0);
        chk("rst_b_out_valid", {63'd0, b_out_valid}, 64'd0);
        chk("rst_b_block_count", 64'(b_block_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        msg_q = '{8'h61, 8'h62, 8'h63};
        send_msg(1'b0, "abc");
        fill_msg(0, 0);
        send_msg(1'b0, "empty");
        fill_msg(56, 3);
        send_msg(1'b0, "len56");
        fill_msg(62, 5);
        send_msg(1'b0, "len62");
        fill_msg(64, 9);
        send_msg(1'b0, "len64");

        bp_en = 1'b1;
        msg_q = '{8'h61, 8'h62, 8'h63};
        send_msg(1'b0, "bp_abc");
        fill_msg(56, 3);
        send_msg(1'b0, "bp_len56");
        fill_msg(21, 11);
        send_msg(1'b0, "bp_len21");
        bp_en = 1'b0;
        @(posedge clk);
        #1;

        // Abandon an "abc" message part-way through its zero fill.
        msg_q = '{8'h61, 8'h62, 8'h63};
        build_expected(1'b0);
        drive_words(1'b0);
        t = 0;
        while (exp_a.size() > 10 && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {63'd0, a_out_valid}, 64'd0);
        chk("midrst_in_ready", {63'd0, a_in_ready}, {63'd0, out_ready});
        chk("midrst_block_count", 64'(a_block_count), 64'd0);
        exp_a.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        msg_q = '{8'h61, 8'h62, 8'h63};
        send_msg(1'b0, "post_rst_abc");

        fill_msg(8200, 1);
        send_msg(1'b1, "b_overflow");
        fill_msg(55, 2);
        send_msg(1'b1, "b_len55");
        fill_msg(16, 4);
        send_msg(1'b1, "b_len16");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha_pad_stream.md
# sha_pad_stream

Streaming SHA-256 message padder. It accepts an arbitrary-length byte message as a stream of words and emits the padded message as a stream of words. The padding is the 0x80 marker, the zero fill, and the 64-bit big-endian bit length, and the output is grouped into 512-bit blocks. It sits between the message source and the SHA-256 compression core, replacing the fixed, combinational block-count calculation with a cycle-accurate generator. It also reports the number of 512-bit blocks it produced for each message.

## Interface
Parameters:
- WORD_W, default 32: stream word width; must be one of 8, 16, 32 or 64.
- MSG_LEN_W, default 32: width of the internal bit-length counter, at most 64; the upper 64-MSG_LEN_W bits of the length field are zero.
- Derived: WPB = 512/WORD_W words per block; LW = 64/WORD_W length words; BPW = WORD_W/8 bytes per word.

Ports:
- clk, input, 1: single clock, all state on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: input word valid.
- in_ready, output, 1: input word accepted when in_valid and in_ready are both high.
- in_data, input, WORD_W: message bytes, first byte in the MSBs.
- in_last, input, 1: final word of the message.
- in_bytes, input, $clog2(BPW)+1: valid bytes in the last word, 0..BPW; ignored unless in_last.
- out_valid, output, 1: output word valid.
- out_ready, input, 1: output word consumed when out_valid and out_ready are both high.
- out_data, output, WORD_W: padded message word.
- out_block_last, output, 1: word is index WPB-1 of its block.
- out_msg_last, output, 1: final word of the padded message.
- block_count, output, MSG_LEN_W-8: number of blocks emitted for the last completed message.
- overflow, output, 1: sticky flag; message exceeded the range of the bit-length counter.

## Operation
- States are DATA, PAD, ZERO and LEN; reset enters DATA.
- Counters:
  - word index widx, range 0..WPB-1, wraps at WPB-1 and advances on every output handshake.
  - byte counter, in bytes, with MSG_LEN_W-3 bits.
  - block counter, which increments on every out_block_last handshake.
- DATA:
  - Combinational pass-through: out_valid=in_valid, in_ready=out_ready, out_data=in_data.
  - Each accepted word adds BPW to the byte counter, or in_bytes when it is the last word.
- Last word with in_bytes < BPW:
  - out_data keeps the valid bytes, puts 0x80 in byte position in_bytes, and zeroes the remaining bytes.
  - The 0x80 word is this word.
- Last word with in_bytes = BPW:
  - The word is passed unchanged.
  - Next state is PAD, which emits a single word of 0x80 followed by zeros.
- After the 0x80 word at index i, the next state is ZERO.
  - ZERO emits zero words until widx = WPB-LW.
  - If i ≥ WPB-LW, the zero fill runs through the end of the block and into the next block before reaching WPB-LW.
- LEN:
  - Emits LW words holding the 64-bit value bytes×8, most significant word first.
  - The final length word carries out_block_last=1 and out_msg_last=1.
- On the out_msg_last handshake:
  - block_count latches the block total, which must equal floor((L+64)/512)+1 for L message bits.
  - State returns to DATA with widx, byte counter and block counter cleared.
- in_ready=0 in PAD, ZERO and LEN.
- The empty message is a last word with in_bytes=0. It emits 0x80 followed by zeros, then LEN with value 0.
- Overflow:
  - The byte counter saturates at all ones and sets overflow.
  - The emitted length is then the saturated value.
  - overflow clears on the first input handshake of the next message.
- in_data bytes beyond in_bytes are don't-care and must never reach out_data.

## Timing
- Reset values:
  - out_valid=0.
  - in_ready=out_ready (DATA).
  - out_block_last=0 and out_msg_last=0.
  - block_count=0.
  - overflow=0.
  - All counters 0.
- Reset is asynchronous and may assert mid-message. It abandons the message, and the next accepted word starts a new message at widx=0.
- DATA latency is 0 cycles; input and output share the handshake in the same cycle.
- In PAD, ZERO and LEN, out_valid=1 continuously. Each word is held stable until out_ready.
  - Throughput is 1 word per cycle while out_ready=1.
  - out_data must not change while out_valid=1 and out_ready=0.
- The first word of the next message may be accepted in the cycle after the out_msg_last handshake.
- block_count and the overflow result are updated on the clock edge of the out_msg_last handshake.

## Test plan
- "abc" test (WORD_W=32):
  - Stimulus: 0x61626300 with in_last=1, in_bytes=3.
  - Output: 0x61626380, then 13 words of 0x00000000, then 0x00000000, 0x00000018.
  - Flags: out_block_last and out_msg_last on word 15; block_count=1.
- Empty message:
  - Stimulus: in_bytes=0 with in_last=1.
  - Output: 0x80000000, 13 zero words, then 0, 0.
  - Result: block_count=1.
- 56-byte message:
  - Stimulus: 14 full words.
  - Output: the 0x80000000 word at index 14, a zero at index 15, 14 zeros, then 0x00000000, 0x000001C0.
  - Result: block_count=2, with out_block_last at words 15 and 31.
- Backpressure:
  - Stimulus: out_ready toggled pseudo-randomly on the "abc" and 56-byte cases.
  - Required: identical word sequence, no dropped or duplicated words, and out_data held stable while stalled.
- Reset during ZERO:
  - Stimulus: assert rst during ZERO, then send "abc".
  - Required: out_valid=0 immediately on reset; the "abc" output matches the first test exactly.
- WORD_W=64 and MSG_LEN_W=16 build:
  - Stimulus: 55-byte message, which needs 1 block with length 0x1B8.
  - Required: block_count=1.
  - Stimulus: a stream exceeding 8191 bytes.
  - Required: overflow=1 and length field 0xFFF8.
